// File: rtl/contador_pkg.sv
// Shared definitions for the 4-bit sequence counter and its downstream monitor.
// The same nxt_val function is used by both blocks so that they always agree
// on the sequence order.
package contador_pkg;

    // First and last values of one lap of the sequence.
    localparam logic [3:0] SEQ_FIRST = 4'd1;
    localparam logic [3:0] SEQ_LAST  = 4'd11;

    // Monitor FSM states.
    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    // Successor of v in the sequence 1,3,5,0,2,4,6,7,8,9,10,15,14,13,12,11.
    // Every 4-bit code is a member, so the sequence is a single 16-cycle.
    function automatic logic [3:0] nxt_val(input logic [3:0] v);
        logic [3:0] r;
        case (v)
            4'd1:    r = 4'd3;
            4'd3:    r = 4'd5;
            4'd5:    r = 4'd0;
            4'd0:    r = 4'd2;
            4'd2:    r = 4'd4;
            4'd4:    r = 4'd6;
            4'd6:    r = 4'd7;
            4'd7:    r = 4'd8;
            4'd8:    r = 4'd9;
            4'd9:    r = 4'd10;
            4'd10:   r = 4'd15;
            4'd15:   r = 4'd14;
            4'd14:   r = 4'd13;
            4'd13:   r = 4'd12;
            4'd12:   r = 4'd11;
            4'd11:   r = 4'd1;
            default: r = 4'd1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/contador_sincrono_monitor.sv
// Downstream checker for the 4-bit sequence counter. Predicts each next count
// sample, locks after a run of correct transitions, and reports laps and
// sequence errors. All outputs are registered and describe the sample taken at
// the previous clock edge.
module contador_sincrono_monitor
    import contador_pkg::*;
#(
    parameter logic [3:0]  START_VAL = SEQ_FIRST,
    parameter int unsigned LOCK_CNT  = 4,
    parameter int unsigned LAP_W     = 8,
    parameter int unsigned ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       count,
    input  logic             clr_stats,
    output logic             locked,
    output logic [3:0]       expected,
    output logic             lap_pulse,
    output logic [LAP_W-1:0] lap_count,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [3:0]       LOCK_TARGET = LOCK_CNT[3:0];
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    state_t           state_q,      state_d;
    logic [3:0]       match_cnt_q,  match_cnt_d;
    logic [3:0]       expected_q,   expected_d;
    logic             locked_q,     locked_d;
    logic             lap_pulse_q,  lap_pulse_d;
    logic             err_pulse_q,  err_pulse_d;
    logic [LAP_W-1:0] lap_count_q,  lap_count_d;
    logic [ERR_W-1:0] err_count_q,  err_count_d;
    logic             err_sticky_q, err_sticky_d;

    logic [3:0]       match_inc_s;
    logic [3:0]       succ_s;
    logic             hit_s;

    assign match_inc_s = match_cnt_q + 4'd1;
    assign succ_s      = nxt_val(count);
    assign hit_s       = (count == expected_q);

    // FSM: tracks the prediction, the run of matches and the lap/error events.
    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        expected_d  = expected_q;
        lap_pulse_d = 1'b0;
        err_pulse_d = 1'b0;
        case (state_q)
            UNLOCKED: begin
                // First sample after reset only seeds the prediction.
                expected_d  = succ_s;
                match_cnt_d = 4'd0;
                state_d     = ACQUIRE;
            end
            ACQUIRE: begin
                expected_d = succ_s;
                if (hit_s) begin
                    match_cnt_d = match_inc_s;
                    if (match_inc_s == LOCK_TARGET) begin
                        state_d = LOCKED;
                    end else begin
                        state_d = ACQUIRE;
                    end
                end else begin
                    // Silent restart: errors are only reported once locked.
                    match_cnt_d = 4'd0;
                    state_d     = ACQUIRE;
                end
            end
            LOCKED: begin
                expected_d = succ_s;
                if (hit_s) begin
                    state_d = LOCKED;
                    if (count == START_VAL) begin
                        lap_pulse_d = 1'b1;
                    end else begin
                        lap_pulse_d = 1'b0;
                    end
                end else begin
                    // Resync onto the new value; a stuck count therefore
                    // raises a single error and then just keeps restarting.
                    err_pulse_d = 1'b1;
                    match_cnt_d = 4'd0;
                    state_d     = ACQUIRE;
                end
            end
            default: begin
                state_d     = UNLOCKED;
                match_cnt_d = 4'd0;
                expected_d  = 4'd0;
            end
        endcase
        locked_d = (state_d == LOCKED);
    end

    // Statistics: clr_stats wins over any same-cycle increment or set.
    always_comb begin
        if (clr_stats) begin
            lap_count_d  = '0;
            err_count_d  = '0;
            err_sticky_d = 1'b0;
        end else begin
            if (lap_pulse_d) begin
                lap_count_d = lap_count_q + LAP_W'(1);
            end else begin
                lap_count_d = lap_count_q;
            end
            if (err_pulse_d && (err_count_q != ERR_MAX)) begin
                err_count_d = err_count_q + ERR_W'(1);
            end else begin
                err_count_d = err_count_q;
            end
            if (err_pulse_d) begin
                err_sticky_d = 1'b1;
            end else begin
                err_sticky_d = err_sticky_q;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= UNLOCKED;
            match_cnt_q  <= 4'd0;
            expected_q   <= 4'd0;
            locked_q     <= 1'b0;
            lap_pulse_q  <= 1'b0;
            err_pulse_q  <= 1'b0;
            lap_count_q  <= '0;
            err_count_q  <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            match_cnt_q  <= match_cnt_d;
            expected_q   <= expected_d;
            locked_q     <= locked_d;
            lap_pulse_q  <= lap_pulse_d;
            err_pulse_q  <= err_pulse_d;
            lap_count_q  <= lap_count_d;
            err_count_q  <= err_count_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign locked     = locked_q;
    assign expected   = expected_q;
    assign lap_pulse  = lap_pulse_q;
    assign lap_count  = lap_count_q;
    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_contador_sincrono_monitor.sv
// Self-checking bench for contador_sincrono_monitor. Two instances share the
// stimulus: one with default widths and one with ERR_W=2 to exercise error
// count saturation. A behavioural model built on the sequence table predicts
// every output after every edge.
module tb_contador_sincrono_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] count = 4'd0;
    logic       clr_stats = 1'b0;

    logic       locked, lap_pulse, err_pulse, err_sticky;
    logic [3:0] expected;
    logic [7:0] lap_count, err_count;

    logic       locked2, lap_pulse2, err_pulse2, err_sticky2;
    logic [3:0] expected2;
    logic [7:0] lap_count2;
    logic [1:0] err_count2;

    always #5 clk = ~clk;

    contador_sincrono_monitor u_dut (
        .clk(clk), .rst(rst), .count(count), .clr_stats(clr_stats),
        .locked(locked), .expected(expected), .lap_pulse(lap_pulse),
        .lap_count(lap_count), .err_pulse(err_pulse),
        .err_sticky(err_sticky), .err_count(err_count)
    );

    contador_sincrono_monitor #(.ERR_W(2)) u_dut_e2 (
        .clk(clk), .rst(rst), .count(count), .clr_stats(clr_stats),
        .locked(locked2), .expected(expected2), .lap_pulse(lap_pulse2),
        .lap_count(lap_count2), .err_pulse(err_pulse2),
        .err_sticky(err_sticky2), .err_count(err_count2)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Sequence table; successor is the next entry, wrapping around.
    int seq [16] = '{1, 3, 5, 0, 2, 4, 6, 7, 8, 9, 10, 15, 14, 13, 12, 11};

    function automatic int m_nxt(input int v);
        for (int i = 0; i < 16; i++) begin
            if (seq[i] == v) return seq[(i + 1) % 16];
        end
        return 0;
    endfunction

    // Model: phase 0 = fresh after reset, 1 = hunting for a run, 2 = locked.
    int m_phase = 0;
    int m_run   = 0;
    int m_pred  = 0;
    int m_laps  = 0;
    int m_errs  = 0;
    int m_stk   = 0;
    int m_lp    = 0;
    int m_ep    = 0;
    int cur     = 0;

    task automatic model_update(input int c, input bit clr, input bit r);
        m_lp = 0;
        m_ep = 0;
        if (r) begin
            m_phase = 0; m_run = 0; m_pred = 0;
            m_laps = 0; m_errs = 0; m_stk = 0;
        end else begin
            if (m_phase == 0) begin
                m_phase = 1; m_run = 0;
            end else if (m_phase == 1) begin
                if (c == m_pred) begin
                    m_run++;
                    if (m_run == 4) m_phase = 2;
                end else begin
                    m_run = 0;
                end
            end else begin
                if (c == m_pred) begin
                    if (c == 1) begin
                        m_lp = 1;
                        m_laps = (m_laps + 1) % 256;
                    end
                end else begin
                    m_ep = 1; m_stk = 1; m_errs++;
                    m_phase = 1; m_run = 0;
                end
            end
            m_pred = m_nxt(c);
            if (clr) begin
                m_laps = 0; m_errs = 0; m_stk = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_all();
        chk("locked",      32'(locked),      32'(m_phase == 2));
        chk("expected",    32'(expected),    32'(m_pred));
        chk("lap_pulse",   32'(lap_pulse),   32'(m_lp));
        chk("lap_count",   32'(lap_count),   32'(m_laps));
        chk("err_pulse",   32'(err_pulse),   32'(m_ep));
        chk("err_sticky",  32'(err_sticky),  32'(m_stk));
        chk("err_count",   32'(err_count),   32'((m_errs > 255) ? 255 : m_errs));
        chk("err_count_w2", 32'(err_count2), 32'((m_errs > 3) ? 3 : m_errs));
        chk("locked_w2",   32'(locked2),     32'(m_phase == 2));
    endtask

    task automatic step(input int c, input bit clr, input bit r);
        @(negedge clk);
        count = 4'(c);
        clr_stats = clr;
        rst = r;
        @(posedge clk);
        model_update(c, clr, r);
        cur = c;
        #1;
        check_all();
    endtask

    int laps_seen;
    int n;

    initial begin
        // Reset state.
        step(0, 1'b0, 1'b1);
        step(0, 1'b0, 1'b1);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_expected", 32'(expected), 32'd0);

        // Test 1: acquire and lock on 1,3,5,0,2.
        step(1, 1'b0, 1'b0);
        step(3, 1'b0, 1'b0);
        step(5, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0);
        chk("t1_not_locked", 32'(locked), 32'd0);
        step(2, 1'b0, 1'b0);
        chk("t1_locked", 32'(locked), 32'd1);
        chk("t1_expected", 32'(expected), 32'd4);

        // Test 2: three full laps.
        laps_seen = 0;
        for (int i = 0; i < 44; i++) begin
            step(m_nxt(cur), 1'b0, 1'b0);
            if (lap_pulse === 1'b1) laps_seen++;
        end
        chk("t2_lap_pulses", 32'(laps_seen), 32'd3);
        chk("t2_lap_count", 32'(lap_count), 32'd3);
        chk("t2_err_count", 32'(err_count), 32'd0);

        // Test 3: expecting 5, drive 7, then resync on 8,9,10,15.
        step(3, 1'b0, 1'b0);
        chk("t3_expect5", 32'(expected), 32'd5);
        step(7, 1'b0, 1'b0);
        chk("t3_err_pulse", 32'(err_pulse), 32'd1);
        chk("t3_err_count", 32'(err_count), 32'd1);
        chk("t3_sticky", 32'(err_sticky), 32'd1);
        chk("t3_unlocked", 32'(locked), 32'd0);
        step(8, 1'b0, 1'b0);
        chk("t3_pulse_once", 32'(err_pulse), 32'd0);
        step(9, 1'b0, 1'b0);
        step(10, 1'b0, 1'b0);
        step(15, 1'b0, 1'b0);
        chk("t3_relocked", 32'(locked), 32'd1);

        // Test 4: five separate errors saturate the 2-bit counter.
        step(m_nxt(cur), 1'b1, 1'b0);
        for (int e = 0; e < 5; e++) begin
            step(m_nxt(m_nxt(cur)), 1'b0, 1'b0);
            for (int k = 0; k < 4; k++) step(m_nxt(cur), 1'b0, 1'b0);
        end
        chk("t4_err_count_w2", 32'(err_count2), 32'd3);
        chk("t4_err_count_w8", 32'(err_count), 32'd5);
        chk("t4_sticky", 32'(err_sticky2), 32'd1);

        // Test 5: clr_stats coincident with a mismatch.
        step(m_nxt(m_nxt(cur)), 1'b1, 1'b0);
        chk("t5_err_pulse", 32'(err_pulse), 32'd1);
        chk("t5_err_count", 32'(err_count), 32'd0);
        chk("t5_sticky", 32'(err_sticky), 32'd0);
        chk("t5_acquire", 32'(locked), 32'd0);
        for (int k = 0; k < 4; k++) step(m_nxt(cur), 1'b0, 1'b0);
        chk("t5_relock", 32'(locked), 32'd1);

        // Test 6: reset while locked with two laps, then relock.
        step(m_nxt(cur), 1'b1, 1'b0);
        for (int k = 0; k < 40 && m_laps < 2; k++) step(m_nxt(cur), 1'b0, 1'b0);
        chk("t6_laps2", 32'(lap_count), 32'd2);
        step(m_nxt(cur), 1'b0, 1'b1);
        chk("t6_rst_locked", 32'(locked), 32'd0);
        chk("t6_rst_expected", 32'(expected), 32'd0);
        chk("t6_rst_lap_count", 32'(lap_count), 32'd0);
        chk("t6_rst_lap_pulse", 32'(lap_pulse), 32'd0);
        chk("t6_rst_err_pulse", 32'(err_pulse), 32'd0);
        chk("t6_rst_err_count", 32'(err_count), 32'd0);
        chk("t6_rst_sticky", 32'(err_sticky), 32'd0);
        n = 0;
        for (int k = 0; k < 20 && locked !== 1'b1; k++) begin
            step(m_nxt(cur), 1'b0, 1'b0);
            n++;
        end
        chk("t6_relock_samples", 32'(n), 32'd5);

        // Randomized phase: mostly good sequence with glitches, stalls,
        // occasional clears and resets.
        for (int i = 0; i < 800; i++) begin
            int r;
            int c;
            bit clr;
            bit rr;
            r = int'($urandom_range(0, 99));
            if (r < 6) c = int'($urandom_range(0, 15));
            else if (r < 9) c = cur;
            else c = m_nxt(cur);
            clr = ($urandom_range(0, 39) == 0);
            rr  = ($urandom_range(0, 299) == 0);
            step(c, clr, rr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
